periph_bus_ctrl: RTL and testbench

Bus-side sequencer that sits directly upstream of the bidirectional peripheral port. It converts single-word CPU load/store requests into the port's shared data_bus transfers and the READ_IN / LOAD_OUT / LOAD_DIR strobes. It keeps a shadow of the direction register and transfer counters, and resolves bus turnaround so that the controller and the port never drive data_bus in the same cycle.

---
 rtl/periph_bus_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_periph_bus_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl: sequences single-word CPU loads/stores onto the peripheral port's shared data_bus.
// Optional background input polling with a sticky change interrupt when PERIPH_POLL_IRQ_EN is defined.
module periph_bus_ctrl #(
  parameter int unsigned N        = 64,
  parameter int unsigned POLL_DIV = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [1:0]   cpu_addr,
  input  logic [N-1:0] cpu_wdata,
  output logic [N-1:0] cpu_rdata,
  output logic         cpu_ack,
  output logic         cpu_err,
  inout  wire  [N-1:0] data_bus,
  output logic         READ_IN,
  output logic         LOAD_OUT,
  output logic         LOAD_DIR,
  output logic         irq
);

  localparam int unsigned CW     = 8;
  localparam logic [1:0]  A_DATA = 2'b00;
  localparam logic [1:0]  A_DIR  = 2'b01;
  localparam logic [1:0]  A_STAT = 2'b10;

  if (POLL_DIV < 4) begin : g_bad_poll_div
    $error("POLL_DIV must be >= 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_ACK, S_TURN} state_t;

  typedef struct packed {
    logic         we;
    logic [1:0]   addr;
    logic [N-1:0] wdata;
  } req_t;

  state_t        r_state, w_state_nxt;
  req_t          r_req, w_req_nxt;
  logic [N-1:0]  r_dir, w_dir_nxt;
  logic [CW-1:0] r_wr_cnt, w_wr_cnt_nxt;
  logic [CW-1:0] r_rd_cnt, w_rd_cnt_nxt;
  logic          r_bus_oe, w_bus_oe_nxt;
  logic [N-1:0]  r_bus_q, w_bus_q_nxt;
  logic [N-1:0]  w_rdata_nxt;
  logic          w_ack_nxt, w_err_nxt;
  logic          w_read_in_nxt, w_load_out_nxt, w_load_dir_nxt;
  logic          w_acc_err;
  logic [2:0]    w_strb;
  logic          w_irq_bit;
  logic [N-1:0]  w_status;

`ifdef PERIPH_POLL_IRQ_EN
  localparam int unsigned   PW        = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);

  logic [PW-1:0] r_poll_cnt, w_poll_cnt_nxt;
  logic          r_poll, w_poll_nxt;
  logic [N-1:0]  r_last_in, w_last_in_nxt;
  logic          w_irq_set, w_irq_clr, w_irq_nxt;

  assign w_irq_bit = irq;
`else
  assign w_irq_bit = 1'b0;
  assign irq       = 1'b0;
`endif

  // Strobe set for an access, ordered {READ_IN, LOAD_OUT, LOAD_DIR}
  function automatic logic [2:0] f_strobes(input logic we, input logic [1:0] addr);
    f_strobes = 3'b000;
    if (we && (addr == A_DATA))       f_strobes = 3'b010;
    else if (we && (addr == A_DIR))   f_strobes = 3'b001;
    else if (!we && (addr == A_DATA)) f_strobes = 3'b100;
  endfunction

  assign w_strb    = f_strobes(cpu_we, cpu_addr);
  assign w_acc_err = (r_req.addr == 2'b11) || (r_req.we && (r_req.addr == A_STAT));
  assign data_bus  = r_bus_oe ? r_bus_q : {N{1'bz}};

  always_comb begin
    w_status              = '0;
    w_status[CW-1:0]      = r_rd_cnt;
    w_status[2*CW-1:CW]   = r_wr_cnt;
    w_status[2*CW]        = w_irq_bit;
  end

  // Next-state and next-output logic; all outputs are registered from these values
  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_dir_nxt      = r_dir;
    w_wr_cnt_nxt   = r_wr_cnt;
    w_rd_cnt_nxt   = r_rd_cnt;
    w_bus_oe_nxt   = 1'b0;
    w_bus_q_nxt    = r_bus_q;
    w_rdata_nxt    = cpu_rdata;
    w_ack_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_read_in_nxt  = 1'b0;
    w_load_out_nxt = 1'b0;
    w_load_dir_nxt = 1'b0;
`ifdef PERIPH_POLL_IRQ_EN
    w_poll_cnt_nxt = '0;
    w_poll_nxt     = r_poll;
    w_last_in_nxt  = r_last_in;
    w_irq_set      = 1'b0;
    w_irq_clr      = 1'b0;
    w_irq_nxt      = irq;
`endif

    case (r_state)
      S_IDLE: begin
        if (cpu_req) begin
          w_state_nxt = S_XFER;
          w_req_nxt   = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
          {w_read_in_nxt, w_load_out_nxt, w_load_dir_nxt} = w_strb;
          w_bus_oe_nxt = w_strb[1] | w_strb[0];
          w_bus_q_nxt  = cpu_wdata;
`ifdef PERIPH_POLL_IRQ_EN
          w_poll_nxt   = 1'b0;
        end else if (r_poll_cnt == POLL_LAST) begin
          w_state_nxt   = S_XFER;
          w_poll_nxt    = 1'b1;
          w_read_in_nxt = 1'b1;
        end else begin
          w_poll_cnt_nxt = r_poll_cnt + 1'b1;
`endif
        end
      end

      S_XFER: begin
`ifdef PERIPH_POLL_IRQ_EN
        if (r_poll) begin
          // Background sample: flag changes on input-direction bits only
          w_state_nxt   = S_TURN;
          w_irq_set     = |((data_bus ^ r_last_in) & ~r_dir);
          w_last_in_nxt = data_bus;
        end else begin
`endif
          w_state_nxt = S_ACK;
          w_ack_nxt   = 1'b1;
          w_err_nxt   = w_acc_err;
          if (w_acc_err) begin
            w_rdata_nxt = '0;
          end else if (r_req.we) begin
            w_wr_cnt_nxt = r_wr_cnt + 1'b1;
            if (r_req.addr == A_DIR) w_dir_nxt = r_req.wdata;
          end else begin
            case (r_req.addr)
              A_DATA: begin
                w_rdata_nxt  = data_bus;
                w_rd_cnt_nxt = r_rd_cnt + 1'b1;
`ifdef PERIPH_POLL_IRQ_EN
                w_last_in_nxt = data_bus;
`endif
              end
              A_DIR:   w_rdata_nxt = r_dir;
              default: w_rdata_nxt = w_status;
            endcase
          end
`ifdef PERIPH_POLL_IRQ_EN
        end
`endif
      end

      S_ACK: begin
        w_state_nxt = S_TURN;
`ifdef PERIPH_POLL_IRQ_EN
        w_irq_clr = !r_req.we && (r_req.addr == A_STAT);
`endif
      end

      S_TURN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

`ifdef PERIPH_POLL_IRQ_EN
    w_irq_nxt = w_irq_set | (irq & ~w_irq_clr);
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_req     <= '0;
      r_dir     <= '0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_bus_oe  <= 1'b0;
      r_bus_q   <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      READ_IN   <= 1'b0;
      LOAD_OUT  <= 1'b0;
      LOAD_DIR  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= w_req_nxt;
      r_dir     <= w_dir_nxt;
      r_wr_cnt  <= w_wr_cnt_nxt;
      r_rd_cnt  <= w_rd_cnt_nxt;
      r_bus_oe  <= w_bus_oe_nxt;
      r_bus_q   <= w_bus_q_nxt;
      cpu_rdata <= w_rdata_nxt;
      cpu_ack   <= w_ack_nxt;
      cpu_err   <= w_err_nxt;
      READ_IN   <= w_read_in_nxt;
      LOAD_OUT  <= w_load_out_nxt;
      LOAD_DIR  <= w_load_dir_nxt;
    end
  end

`ifdef PERIPH_POLL_IRQ_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_poll_cnt <= '0;
      r_poll     <= 1'b0;
      r_last_in  <= '0;
      irq        <= 1'b0;
    end else begin
      r_poll_cnt <= w_poll_cnt_nxt;
      r_poll     <= w_poll_nxt;
      r_last_in  <= w_last_in_nxt;
      irq        <= w_irq_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Scoreboard bench for periph_bus_ctrl; also builds with PERIPH_POLL_IRQ_EN for the poll/irq checks.
`timescale 1ns/1ps
module tb_periph_bus_ctrl;

  localparam int unsigned N     = 64;
  localparam int          BOUND = 40;
  localparam logic [1:0]  A_DATA = 2'b00;
  localparam logic [1:0]  A_DIR  = 2'b01;
  localparam logic [1:0]  A_STAT = 2'b10;
  localparam logic [1:0]  A_BAD  = 2'b11;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [1:0]   cpu_addr = 2'b00;
  logic [N-1:0] cpu_wdata = '0;
  logic [N-1:0] cpu_rdata;
  logic         cpu_ack, cpu_err;
  wire  [N-1:0] data_bus;
  logic         READ_IN, LOAD_OUT, LOAD_DIR, irq;
  logic [N-1:0] port_in = '0;

  typedef struct {
    logic [N-1:0] rdata;
    logic [N-1:0] mask;
    logic         err;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         sb_e;
  int           n_vec = 0;
  int           n_miss = 0;
  logic [N-1:0] m_dir = '0;
  logic [7:0]   m_wr = '0;
  logic [7:0]   m_rd = '0;
  logic         m_irq = 1'b0;
  logic         m_irq_dc = 1'b0;

  periph_bus_ctrl #(.N(N), .POLL_DIV(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .data_bus  (data_bus),
    .READ_IN   (READ_IN),
    .LOAD_OUT  (LOAD_OUT),
    .LOAD_DIR  (LOAD_DIR),
    .irq       (irq)
  );

  // Port model: drives its sampled inputs only while READ_IN is high
  assign data_bus = READ_IN ? port_in : {N{1'bz}};

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic bus_idle();
    return (data_bus === {N{1'bz}}) || (data_bus === {N{1'b0}});
  endfunction

  function automatic logic [N-1:0] f_stat();
    logic [N-1:0] s;
    s        = '0;
    s[7:0]   = m_rd;
    s[15:8]  = m_wr;
    s[16]    = m_irq;
    return s;
  endfunction

  function automatic logic [N-1:0] f_stat_mask();
    logic [N-1:0] m;
    m = {N{1'b1}};
    if (m_irq_dc) m[16] = 1'b0;
    return m;
  endfunction

  always @(negedge clock) begin
    if (reset && cpu_ack) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_ack", N'(cpu_ack), N'(0));
      end else begin
        sb_e = sb_q.pop_front();
        check_eq("rdata", cpu_rdata & sb_e.mask, sb_e.rdata & sb_e.mask);
        check_eq("err", N'(cpu_err), N'(sb_e.err));
      end
    end
  end

  // Bus ownership and strobe exclusivity, every cycle out of reset
  always @(negedge clock) begin
    if (reset) begin
      check_eq("one_strobe", N'($countones({READ_IN, LOAD_OUT, LOAD_DIR}) <= 1), N'(1));
      if (LOAD_OUT || LOAD_DIR) check_eq("bus_wr", data_bus, cpu_wdata);
      else if (READ_IN)         check_eq("bus_rd", data_bus, port_in);
      else                      check_eq("bus_z", N'(bus_idle()), N'(1));
    end
  end

  task automatic txn(input logic we, input logic [1:0] addr, input logic [N-1:0] wdata,
                     input logic [N-1:0] exp_rd, input logic [N-1:0] mask, input logic exp_err,
                     input int exp_ri, input int exp_lo, input int exp_ld);
    int   n_ri, n_lo, n_ld, lat;
    logic got;
    n_ri = 0; n_lo = 0; n_ld = 0; lat = 0; got = 1'b0;
    sb_q.push_back('{rdata: exp_rd, mask: mask, err: exp_err});
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    for (int i = 1; i <= BOUND && !got; i++) begin
      @(negedge clock);
      n_ri += int'(READ_IN);
      n_lo += int'(LOAD_OUT);
      n_ld += int'(LOAD_DIR);
      if (cpu_ack) begin
        got = 1'b1;
        lat = i;
      end
    end
    cpu_req = 1'b0;
    check_eq("ack_seen", N'(got), N'(1));
    if (!got) void'(sb_q.pop_back());
`ifndef PERIPH_POLL_IRQ_EN
    check_eq("ack_latency", N'(lat), N'(2));
    check_eq("n_read_in", N'(n_ri), N'(exp_ri));
`endif
    check_eq("n_load_out", N'(n_lo), N'(exp_lo));
    check_eq("n_load_dir", N'(n_ld), N'(exp_ld));
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic wr_data(input logic [N-1:0] v);
    txn(1'b1, A_DATA, v, '0, '0, 1'b0, 0, 1, 0);
    m_wr++;
  endtask

  task automatic wr_dir(input logic [N-1:0] v);
    txn(1'b1, A_DIR, v, '0, '0, 1'b0, 0, 0, 1);
    m_dir = v;
    m_wr++;
  endtask

  task automatic rd_data();
    txn(1'b0, A_DATA, '0, port_in, {N{1'b1}}, 1'b0, 1, 0, 0);
    m_rd++;
  endtask

  task automatic rd_dir();
    txn(1'b0, A_DIR, '0, m_dir, {N{1'b1}}, 1'b0, 0, 0, 0);
  endtask

  task automatic rd_stat();
    txn(1'b0, A_STAT, '0, f_stat(), f_stat_mask(), 1'b0, 0, 0, 0);
`ifdef PERIPH_POLL_IRQ_EN
    m_irq = 1'b0;
`endif
  endtask

  task automatic err_txn(input logic we, input logic [1:0] addr, input logic [N-1:0] v);
    txn(we, addr, v, '0, {N{1'b1}}, 1'b1, 0, 0, 0);
  endtask

  task automatic b2b_dir_reads(input int n);
    int t_ack[$];
    int cyc, n_ri;
    cyc = 0; n_ri = 0;
    for (int k = 0; k < n; k++) sb_q.push_back('{rdata: m_dir, mask: {N{1'b1}}, err: 1'b0});
    cpu_we = 1'b0; cpu_addr = A_DIR; cpu_req = 1'b1;
    while (t_ack.size() < n && cyc < 20 * n) begin
      @(negedge clock);
      cyc++;
      n_ri += int'(READ_IN);
      if (cpu_ack) t_ack.push_back(cyc);
      if (t_ack.size() == n) cpu_req = 1'b0;
    end
    cpu_req = 1'b0;
    check_eq("b2b_acks", N'(t_ack.size()), N'(n));
    for (int k = 1; k < t_ack.size(); k++)
      check_eq("b2b_spacing", N'(t_ack[k] - t_ack[k-1]), N'(4));
`ifndef PERIPH_POLL_IRQ_EN
    check_eq("b2b_read_in", N'(n_ri), N'(0));
`endif
    @(negedge clock);
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_miss);
    $fatal(1);
  end

  initial begin
    logic got;
`ifdef PERIPH_POLL_IRQ_EN
    m_irq_dc = 1'b1;
`endif
    repeat (3) @(negedge clock);
    check_eq("rst_ack", N'(cpu_ack), N'(0));
    check_eq("rst_err", N'(cpu_err), N'(0));
    check_eq("rst_read_in", N'(READ_IN), N'(0));
    check_eq("rst_load_out", N'(LOAD_OUT), N'(0));
    check_eq("rst_load_dir", N'(LOAD_DIR), N'(0));
    check_eq("rst_irq", N'(irq), N'(0));
    check_eq("rst_rdata", cpu_rdata, '0);
    check_eq("rst_bus_z", N'(bus_idle()), N'(1));
    reset = 1'b1;

    // Reset in the middle of a DIR write abandons it
    wr_dir(64'h1234);
    cpu_we = 1'b1; cpu_addr = A_DIR; cpu_wdata = 64'h5555; cpu_req = 1'b1;
    @(negedge clock);
    check_eq("midx_load_dir", N'(LOAD_DIR), N'(1));
    #2 reset = 1'b0;
    cpu_req = 1'b0;
    @(negedge clock);
    check_eq("midx_strobes", N'({READ_IN, LOAD_OUT, LOAD_DIR}), N'(0));
    check_eq("midx_ack", N'(cpu_ack), N'(0));
    check_eq("midx_bus_z", N'(bus_idle()), N'(1));
    reset = 1'b1;
    m_dir = '0; m_wr = '0; m_rd = '0; m_irq = 1'b0;
    @(negedge clock);
    rd_dir();
    rd_stat();

    wr_data(64'hDEAD_BEEF_0123_4567);
    rd_stat();

    wr_dir(64'h00FF);
    rd_dir();
    port_in = 64'hA5A5;
    rd_data();
    rd_stat();

    err_txn(1'b1, A_STAT, 64'h77);
    err_txn(1'b0, A_BAD, '0);
    err_txn(1'b1, A_BAD, 64'h99);
    rd_stat();

    b2b_dir_reads(3);

    for (int k = 0; k < 256; k++) wr_data({$urandom(), $urandom()} | 64'h1);
    rd_stat();
    while (m_wr != 8'd0) wr_data({$urandom(), $urandom()} | 64'h1);
    rd_stat();

`ifdef PERIPH_POLL_IRQ_EN
    wr_dir('0);
    port_in = 64'h1000;
    rd_data();
    repeat (40) @(negedge clock);
    m_irq_dc = 1'b1;
    rd_stat();
    m_irq_dc = 1'b0;
    m_irq = 1'b0;
    rd_stat();

    port_in = port_in ^ 64'h8;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (irq) got = 1'b1;
    end
    check_eq("irq_rise", N'(got), N'(1));
    m_irq = 1'b1;
    rd_stat();
    check_eq("irq_cleared", N'(irq), N'(0));

    wr_dir(64'h20);
    port_in = port_in ^ 64'h20;
    repeat (40) @(negedge clock);
    check_eq("irq_output_bit", N'(irq), N'(0));
    rd_stat();
`else
    got = 1'b0;
    repeat (40) @(negedge clock) if (irq) got = 1'b1;
    check_eq("irq_tied", N'(got), N'(0));
`endif

    check_eq("sb_drained", N'(sb_q.size()), N'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
